// File: rtl/rr_switch_pkg.sv
// rr_switch_pkg: shared defaults and helpers for the round-robin switch unit.
//   DEF_NUM_INPORTS / DEF_DATA_WIDTH : default parameterisation
//   TAIL_BIT                         : tail-flag bit position for the default width
//   sel_width()                      : width of a grant index for n requesters
//   tail_bit()                       : tail-flag bit position for a given width
// Optional packet lock (RR_SWITCH_UNIT_PKT_LOCK_EN) uses the tail-flag helpers.
package rr_switch_pkg;

   localparam int unsigned DEF_NUM_INPORTS = 5;
   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned TAIL_BIT        = DEF_DATA_WIDTH - 1;

   // A single requester still needs a 1-bit index
   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Tail flag is the message MSB
   function automatic int unsigned tail_bit(input int unsigned w);
      return w - 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter with an owned priority pointer.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req_i       : request vector, one bit per requester
//   en_i        : arbitration enable; no grant is issued when low
//   adv_i       : allow the priority pointer to move past a granted requester
//   grant_c_o   : one-hot grant (combinational), zero when disabled or idle
//   idx_c_o     : index of the winning requester (combinational)
module rr_arbiter
   import rr_switch_pkg::*;
#(
   parameter  int unsigned p_num_req   = DEF_NUM_INPORTS,
   localparam int unsigned c_idx_width = sel_width(p_num_req)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [p_num_req-1:0]   req_i,
   input  logic                   en_i,
   input  logic                   adv_i,
   output logic [p_num_req-1:0]   grant_c_o,
   output logic [c_idx_width-1:0] idx_c_o
);

   logic [c_idx_width-1:0] prio_q, prio_d;
   logic                   found;

   // Scan from prio_q upward, wrapping at p_num_req-1
   always_comb begin
      int unsigned pos;
      pos       = 0;
      found     = 1'b0;
      idx_c_o   = '0;
      grant_c_o = '0;
      for (int unsigned k = 0; k < p_num_req; k++) begin
         pos = 32'(prio_q) + k;
         if (pos >= p_num_req) begin
            pos = pos - p_num_req;
         end
         if (!found && req_i[c_idx_width'(pos)]) begin
            found   = 1'b1;
            idx_c_o = c_idx_width'(pos);
         end
      end
      if (en_i && found) begin
         grant_c_o[idx_c_o] = 1'b1;
      end
   end

   // Pointer moves to one past the winner so it gets lowest priority next
   always_comb begin
      prio_d = prio_q;
      if (en_i && found && adv_i) begin
         if (idx_c_o == c_idx_width'(p_num_req - 1)) begin
            prio_d = '0;
         end else begin
            prio_d = c_idx_width'(idx_c_o + 1'b1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q <= '0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/rr_switch_unit.sv
// rr_switch_unit: round-robin output arbiter sharing one en/rdy channel among
// p_num_inports input queues, with a one-entry output buffer.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   in_deq_rdy  : queue i non-empty
//   in_deq_en   : dequeue strobe to queue i (one-hot or zero)
//   in_deq_msg  : flattened head messages, queue i at [i*W +: W]
//   out_en      : downstream enqueue strobe
//   out_rdy     : downstream can accept
//   out_msg     : buffered message
//   grant_sel   : index of the most recently granted queue
//   busy        : output buffer holds a message
// Optional feature macro: RR_SWITCH_UNIT_PKT_LOCK_EN (packet lock on the
// message MSB tail flag; a granted non-tail flit locks arbitration to its queue).
module rr_switch_unit
   import rr_switch_pkg::*;
#(
   parameter  int unsigned p_num_inports = DEF_NUM_INPORTS,
   parameter  int unsigned p_data_width  = DEF_DATA_WIDTH,
   localparam int unsigned c_sel_width   = sel_width(p_num_inports)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [p_num_inports-1:0]              in_deq_rdy,
   output logic [p_num_inports-1:0]              in_deq_en,
   input  logic [p_num_inports*p_data_width-1:0] in_deq_msg,
   output logic                                  out_en,
   input  logic                                  out_rdy,
   output logic [p_data_width-1:0]               out_msg,
   output logic [c_sel_width-1:0]                grant_sel,
   output logic                                  busy
);

   logic                     buf_valid_q, buf_valid_d;
   logic [p_data_width-1:0]  buf_msg_q, buf_msg_d;
   logic [c_sel_width-1:0]   grant_sel_q, grant_sel_d;

   logic                     can_accept;
   logic                     arb_en;
   logic                     arb_adv;
   logic [p_num_inports-1:0] arb_req;
   logic [p_num_inports-1:0] arb_grant;
   logic [c_sel_width-1:0]   arb_idx;
   logic                     granted;
   logic [p_data_width-1:0]  sel_msg;

   // Downstream handshake straight off the buffer
   assign out_en    = buf_valid_q & out_rdy;
   assign busy      = buf_valid_q;
   assign out_msg   = buf_msg_q;
   assign grant_sel = grant_sel_q;

   // Drain and refill may happen in the same cycle; never dequeue while reset is held
   assign can_accept = ~buf_valid_q | out_en;
   assign arb_en     = can_accept & ~reset;

   rr_arbiter #(
      .p_num_req (p_num_inports)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req_i     (arb_req),
      .en_i      (arb_en),
      .adv_i     (arb_adv),
      .grant_c_o (arb_grant),
      .idx_c_o   (arb_idx)
   );

   assign in_deq_en = arb_grant;
   assign granted   = |arb_grant;
   assign sel_msg   = in_deq_msg[32'(arb_idx) * p_data_width +: p_data_width];

`ifdef RR_SWITCH_UNIT_PKT_LOCK_EN
   localparam int unsigned c_tail_bit = tail_bit(p_data_width);

   logic                   lock_q, lock_d;
   logic [c_sel_width-1:0] lock_sel_q, lock_sel_d;
   logic                   is_tail;

   assign is_tail = sel_msg[c_tail_bit];

   // While locked only the owning queue may be granted, even if it stalls
   always_comb begin
      arb_req = in_deq_rdy;
      if (lock_q) begin
         arb_req             = '0;
         arb_req[lock_sel_q] = in_deq_rdy[lock_sel_q];
      end
   end

   // Pointer moves only at packet boundaries
   assign arb_adv = is_tail;

   // Lock opens on a non-tail grant and closes when the tail is granted
   always_comb begin
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      if (granted) begin
         lock_d     = ~is_tail;
         lock_sel_d = arb_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q     <= 1'b0;
         lock_sel_q <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
      end
   end
`else
   assign arb_req = in_deq_rdy;
   assign arb_adv = 1'b1;
`endif

   // Output buffer next state; buf_msg keeps its stale value on a plain drain
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_msg_d   = buf_msg_q;
      grant_sel_d = grant_sel_q;
      if (out_en) begin
         buf_valid_d = 1'b0;
      end
      if (granted) begin
         buf_valid_d = 1'b1;
         buf_msg_d   = sel_msg;
         grant_sel_d = arb_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid_q <= 1'b0;
         buf_msg_q   <= '0;
         grant_sel_q <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_msg_q   <= buf_msg_d;
         grant_sel_q <= grant_sel_d;
      end
   end

endmodule

// File: tb/tb_rr_switch_unit.sv
// tb_rr_switch_unit: self-checking bench for rr_switch_unit (4 queues, 8-bit messages).
// Vector rows give per-cycle inputs and expected strobes; granted messages are
// pushed to a scoreboard and checked when they appear at the output.
// Packet-lock rows run only when RR_SWITCH_UNIT_PKT_LOCK_EN is defined.
module tb_rr_switch_unit;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic           clk;
   logic           reset;
   logic [N-1:0]   in_deq_rdy;
   logic [N-1:0]   in_deq_en;
   logic [N*W-1:0] in_deq_msg;
   logic           out_en;
   logic           out_rdy;
   logic [W-1:0]   out_msg;
   logic [1:0]     grant_sel;
   logic           busy;

   rr_switch_unit #(
      .p_num_inports (N),
      .p_data_width  (W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_deq_rdy (in_deq_rdy),
      .in_deq_en  (in_deq_en),
      .in_deq_msg (in_deq_msg),
      .out_en     (out_en),
      .out_rdy    (out_rdy),
      .out_msg    (out_msg),
      .grant_sel  (grant_sel),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   rdy;
      logic [N*W-1:0] msgs;
      logic           ordy;
      logic [N-1:0]   exp_deq;
      logic           exp_out;
      logic           exp_busy;
   } row_t;

   typedef struct {
      logic [W-1:0] msg;
      logic [1:0]   sel;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive at posedge+1, check at negedge, return at next posedge+1
   task automatic apply_row(input row_t r, input string tag, input int id);
      exp_t e;
      logic [N*W-1:0] m;
      in_deq_rdy = r.rdy;
      in_deq_msg = r.msgs;
      out_rdy    = r.ordy;
      @(negedge clk);
      check($sformatf("%s%0d deq_en", tag, id), 32'(in_deq_en), 32'(r.exp_deq));
      check($sformatf("%s%0d out_en", tag, id), 32'(out_en), 32'(r.exp_out));
      check($sformatf("%s%0d busy", tag, id), 32'(busy), 32'(r.exp_busy));
      if (out_en || busy) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s%0d scoreboard: output valid with nothing expected", tag, id);
         end else begin
            e = sb[0];
            check($sformatf("%s%0d out_msg", tag, id), 32'(out_msg), 32'(e.msg));
            check($sformatf("%s%0d grant_sel", tag, id), 32'(grant_sel), 32'(e.sel));
            if (out_en) void'(sb.pop_front());
         end
      end
      if (r.exp_deq != '0) begin
         m = r.msgs;
         for (int i = 0; i < int'(N); i++) begin
            if (r.exp_deq[i]) begin
               e.msg = m[i*W +: W];
               e.sel = 2'(i);
               sb.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   row_t main_tbl[14];
`ifdef RR_SWITCH_UNIT_PKT_LOCK_EN
   row_t lock_tbl[7];
`endif

   initial begin
      logic [N*W-1:0] mq;
      n_cmp = 0;
      n_bad = 0;
      // q3=D3 q2=A5 q1=F2 q0=C1; all carry the MSB set
      mq = 32'hD3A5_F2C1;
      //               rdy      msgs ordy  exp_deq  out   busy
      main_tbl[0]  = '{4'b0100, mq, 1'b1, 4'b0100, 1'b0, 1'b0};
      main_tbl[1]  = '{4'b0000, mq, 1'b1, 4'b0000, 1'b1, 1'b1};
      main_tbl[2]  = '{4'b1000, mq, 1'b1, 4'b1000, 1'b0, 1'b0};
      main_tbl[3]  = '{4'b1111, mq, 1'b1, 4'b0001, 1'b1, 1'b1};
      main_tbl[4]  = '{4'b1111, mq, 1'b1, 4'b0010, 1'b1, 1'b1};
      main_tbl[5]  = '{4'b1111, mq, 1'b1, 4'b0100, 1'b1, 1'b1};
      main_tbl[6]  = '{4'b1111, mq, 1'b1, 4'b1000, 1'b1, 1'b1};
      main_tbl[7]  = '{4'b1111, mq, 1'b1, 4'b0001, 1'b1, 1'b1};
      main_tbl[8]  = '{4'b1111, mq, 1'b0, 4'b0000, 1'b0, 1'b1};
      main_tbl[9]  = '{4'b1111, mq, 1'b0, 4'b0000, 1'b0, 1'b1};
      main_tbl[10] = '{4'b1111, mq, 1'b0, 4'b0000, 1'b0, 1'b1};
      main_tbl[11] = '{4'b1111, mq, 1'b1, 4'b0010, 1'b1, 1'b1};
      main_tbl[12] = '{4'b0000, mq, 1'b1, 4'b0000, 1'b1, 1'b1};
      main_tbl[13] = '{4'b0000, mq, 1'b1, 4'b0000, 1'b0, 1'b0};
`ifdef RR_SWITCH_UNIT_PKT_LOCK_EN
      lock_tbl[0]  = '{4'b0011, 32'h0000_8001, 1'b1, 4'b0001, 1'b0, 1'b0};
      lock_tbl[1]  = '{4'b0011, 32'h0000_8002, 1'b1, 4'b0001, 1'b1, 1'b1};
      lock_tbl[2]  = '{4'b0010, 32'h0000_8055, 1'b1, 4'b0000, 1'b1, 1'b1};
      lock_tbl[3]  = '{4'b0011, 32'h0000_8083, 1'b1, 4'b0001, 1'b0, 1'b0};
      lock_tbl[4]  = '{4'b0010, 32'h0000_8083, 1'b1, 4'b0010, 1'b1, 1'b1};
      lock_tbl[5]  = '{4'b0000, 32'h0000_8083, 1'b1, 4'b0000, 1'b1, 1'b1};
      lock_tbl[6]  = '{4'b0000, 32'h0000_8083, 1'b1, 4'b0000, 1'b0, 1'b0};
`endif

      // Reset held with every queue ready: nothing may be dequeued
      reset      = 1'b1;
      in_deq_rdy = 4'b1111;
      in_deq_msg = mq;
      out_rdy    = 1'b1;
      #1;
      check("reset deq_en", 32'(in_deq_en), 32'd0);
      check("reset out_en", 32'(out_en), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset grant_sel", 32'(grant_sel), 32'd0);
      check("reset out_msg", 32'(out_msg), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      in_deq_rdy = '0;
      reset      = 1'b0;

      for (int i = 0; i < 14; i++) apply_row(main_tbl[i], "main", i);

      // Load 0x3C from queue 2 under backpressure, then reset between edges
      in_deq_rdy = 4'b0100;
      in_deq_msg = 32'h003C_0000;
      out_rdy    = 1'b0;
      @(negedge clk);
      check("load deq_en", 32'(in_deq_en), 32'b0100);
      @(posedge clk);
      #1;
      check("load busy", 32'(busy), 32'd1);
      check("load out_msg", 32'(out_msg), 32'h3C);
      check("load grant_sel", 32'(grant_sel), 32'd2);
      #2;
      reset   = 1'b1;
      out_rdy = 1'b1;
      #1;
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset out_en", 32'(out_en), 32'd0);
      check("async reset deq_en", 32'(in_deq_en), 32'd0);
      check("async reset grant_sel", 32'(grant_sel), 32'd0);
      check("async reset out_msg", 32'(out_msg), 32'd0);
      @(posedge clk);
      #1;
      reset      = 1'b0;
      in_deq_rdy = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post reset out_en %0d", k), 32'(out_en), 32'd0);
         check($sformatf("post reset busy %0d", k), 32'(busy), 32'd0);
         @(posedge clk);
         #1;
      end
      sb.delete();

`ifdef RR_SWITCH_UNIT_PKT_LOCK_EN
      for (int i = 0; i < 7; i++) apply_row(lock_tbl[i], "lock", i);
`endif

      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
